// File: rtl/rans_byte_packer_if.sv
// -----------------------------------------------------------------------------
// rans_byte_packer_if
// Bundles the encoder-side byte handshake and the AXI-Stream output of the
// rANS byte packer.
//   Encoder side : valid_i[1:0], enc_i[15:0], flush_i  (to packer)
//                  ready_o                             (from packer)
//   Stream side  : m_tdata, m_tkeep, m_tlast, m_tvalid (from packer)
//                  m_tready                            (to packer)
// Modports:
//   slave  - the packer itself
//   master - the environment (encoder + DMA) driving/observing the packer
// -----------------------------------------------------------------------------
interface rans_byte_packer_if #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int OUT_BYTES    = 4
);
  logic [1:0]                          valid_i;
  logic [2*SYMBOL_WIDTH-1:0]           enc_i;
  logic                                ready_o;
  logic                                flush_i;
  logic [OUT_BYTES*SYMBOL_WIDTH-1:0]   m_tdata;
  logic [OUT_BYTES-1:0]                m_tkeep;
  logic                                m_tlast;
  logic                                m_tvalid;
  logic                                m_tready;

  modport slave (
    input  valid_i, enc_i, flush_i, m_tready,
    output ready_o, m_tdata, m_tkeep, m_tlast, m_tvalid
  );

  modport master (
    output valid_i, enc_i, flush_i, m_tready,
    input  ready_o, m_tdata, m_tkeep, m_tlast, m_tvalid
  );
endinterface

// File: rtl/rans_byte_packer.sv
// -----------------------------------------------------------------------------
// rans_byte_packer
// Packs the 0/1/2-byte-per-cycle output of the rANS encoder into 32-bit
// AXI-Stream words (byte 0 = oldest byte). A flush pulse drains the residue
// as a final partial word with TLAST (an empty buffer yields a null TLAST beat).
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   bus (slave)    valid_i/enc_i/flush_i/ready_o encoder handshake and
//                  m_tdata/m_tkeep/m_tlast/m_tvalid/m_tready stream output
//   byte_cnt_o     (RANS_PACK_BYTE_CNT_EN only) bytes emitted in current stream
//   stream_done_o  (RANS_PACK_BYTE_CNT_EN only) pulse when a stream completes
//
// Optional feature macro: RANS_PACK_BYTE_CNT_EN
// -----------------------------------------------------------------------------
module rans_byte_packer #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int OUT_BYTES    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rans_byte_packer_if.slave  bus
`ifdef RANS_PACK_BYTE_CNT_EN
  ,
  output logic [31:0]        byte_cnt_o,
  output logic               stream_done_o
`endif
);

  localparam int BUF_BYTES = 2 * OUT_BYTES;
  localparam int BUF_W     = BUF_BYTES * SYMBOL_WIDTH;
  localparam int OUT_W     = OUT_BYTES * SYMBOL_WIDTH;
  localparam int IN_W      = 2 * SYMBOL_WIDTH;
  localparam int CNT_W     = $clog2(BUF_BYTES + 1);

  localparam logic [CNT_W-1:0]   OUT_N     = CNT_W'(OUT_BYTES);
  // Room for a full 2-byte beat must always remain.
  localparam logic [CNT_W-1:0]   IN_LIMIT  = CNT_W'(BUF_BYTES - 2);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_TWO   = CNT_W'(2);
  localparam logic [OUT_BYTES:0] RAMP_ONE  = {{OUT_BYTES{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [BUF_W-1:0]   buffer;
  logic [BUF_W-1:0]   buffer_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;

  logic               flush_pending;
  logic               tvalid;
  logic               tail;
  logic [OUT_BYTES:0] keep_ramp;
  logic [OUT_BYTES-1:0] keep;
  logic [OUT_W-1:0]   data;
  logic               ready;
  logic               out_fire;
  logic               in_fire;
  logic [CNT_W-1:0]   out_n;
  logic [CNT_W-1:0]   in_n;
  logic [CNT_W-1:0]   remain;
  logic [IN_W-1:0]    in_bytes;
  logic [BUF_W-1:0]   shifted;

  // Output word decode; everything here depends only on registered state.
  always_comb begin
    flush_pending = (state == ST_DRAIN);
    tvalid        = (count >= OUT_N) || flush_pending;
    // The final word of a drain: whatever is left fits in one word.
    tail          = flush_pending && (count <= OUT_N);
    keep_ramp     = (RAMP_ONE << count) - RAMP_ONE;
    ready         = !flush_pending && (count <= IN_LIMIT);
    if (!tvalid) begin
      keep = {OUT_BYTES{1'b0}};
    end else if (tail) begin
      keep = keep_ramp[OUT_BYTES-1:0];
    end else begin
      keep = {OUT_BYTES{1'b1}};
    end
    data = {OUT_W{1'b0}};
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (keep[i]) begin
        data[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = buffer[i*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end else begin
        data[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = {SYMBOL_WIDTH{1'b0}};
      end
    end
  end

  assign bus.ready_o  = ready;
  assign bus.m_tvalid = tvalid;
  assign bus.m_tkeep  = keep;
  assign bus.m_tdata  = data;
  assign bus.m_tlast  = tail;

  // Buffer update: drop the emitted word first, then append the new bytes
  // directly after whatever remains. Bytes at or above count are kept zero.
  always_comb begin
    out_fire = tvalid && bus.m_tready;
    in_fire  = ready && (bus.valid_i != 2'b00);

    if (out_fire) begin
      if (tail) begin
        out_n = count;
      end else begin
        out_n = OUT_N;
      end
    end else begin
      out_n = CNT_ZERO;
    end

    in_n     = CNT_ZERO;
    in_bytes = {IN_W{1'b0}};
    if (in_fire) begin
      case (bus.valid_i)
        2'b01: begin
          in_n     = CNT_ONE;
          in_bytes = {{SYMBOL_WIDTH{1'b0}}, bus.enc_i[SYMBOL_WIDTH-1:0]};
        end
        2'b10: begin
          in_n     = CNT_ONE;
          in_bytes = {{SYMBOL_WIDTH{1'b0}}, bus.enc_i[IN_W-1:SYMBOL_WIDTH]};
        end
        2'b11: begin
          in_n     = CNT_TWO;
          in_bytes = bus.enc_i;
        end
        default: begin
          in_n     = CNT_ZERO;
          in_bytes = {IN_W{1'b0}};
        end
      endcase
    end else begin
      in_n     = CNT_ZERO;
      in_bytes = {IN_W{1'b0}};
    end

    shifted     = buffer >> (out_n * SYMBOL_WIDTH);
    remain      = count - out_n;
    buffer_next = shifted | ({{(BUF_W-IN_W){1'b0}}, in_bytes} << (remain * SYMBOL_WIDTH));
    count_next  = remain + in_n;
  end

  // Next-state logic: flush arms the drain, the TLAST handshake ends it.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (bus.flush_i) begin
          state_next = ST_DRAIN;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (out_fire && tail) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State, buffer and byte count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_RUN;
      buffer <= {BUF_W{1'b0}};
      count  <= CNT_ZERO;
    end else begin
      state  <= state_next;
      buffer <= buffer_next;
      count  <= count_next;
    end
  end

`ifdef RANS_PACK_BYTE_CNT_EN
  function automatic logic [31:0] popcount(input logic [OUT_BYTES-1:0] v);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      s = s + {31'd0, v[i]};
    end
    return s;
  endfunction

  logic [31:0] add_bytes;

  // Bytes leaving on this cycle's output handshake.
  always_comb begin
    if (out_fire) begin
      add_bytes = popcount(keep);
    end else begin
      add_bytes = 32'd0;
    end
  end

  // Per-stream byte total; the cycle after stream_done_o starts a new count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt_o    <= 32'd0;
      stream_done_o <= 1'b0;
    end else begin
      stream_done_o <= out_fire && tail;
      if (stream_done_o) begin
        byte_cnt_o <= add_bytes;
      end else begin
        byte_cnt_o <= byte_cnt_o + add_bytes;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rans_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_rans_byte_packer
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a byte-queue reference model of the packer.
// -----------------------------------------------------------------------------
module tb_rans_byte_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rans_byte_packer_if bus ();

`ifdef RANS_PACK_BYTE_CNT_EN
  logic [31:0] byte_cnt;
  logic        stream_done;
`endif

  rans_byte_packer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef RANS_PACK_BYTE_CNT_EN
    ,
    .byte_cnt_o    (byte_cnt),
    .stream_done_o (stream_done)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the buffered bytes in arrival order, and the flush flag.
  logic [7:0] q[$];
  bit         drain = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check the outputs of the current state against
  // the model, then advance the model as the DUT will on the coming edge.
  task automatic step(input logic [1:0] v, input logic [15:0] e, input logic f, input logic tr);
    int         n;
    bit         exp_valid, exp_last, exp_ready, was_drain;
    logic [3:0] exp_keep;
    logic [31:0] exp_data;
    @(negedge clk);
    bus.valid_i  = v;
    bus.enc_i    = e;
    bus.flush_i  = f;
    bus.m_tready = tr;
    #1;
    n         = (q.size() < 4) ? q.size() : 4;
    exp_valid = (q.size() >= 4) || drain;
    exp_last  = drain && (q.size() <= 4);
    exp_ready = !drain && (q.size() <= 6);
    exp_keep  = 4'h0;
    exp_data  = 32'h0;
    if (exp_valid) begin
      for (int i = 0; i < n; i++) begin
        exp_keep[i]        = 1'b1;
        exp_data[8*i +: 8] = q[i];
      end
    end
    check("ready_o", {31'd0, bus.ready_o}, {31'd0, exp_ready});
    check("m_tvalid", {31'd0, bus.m_tvalid}, {31'd0, exp_valid});
    check("m_tkeep", {28'd0, bus.m_tkeep}, {28'd0, exp_keep});
    check("m_tdata", bus.m_tdata, exp_data);
    check("m_tlast", {31'd0, bus.m_tlast}, {31'd0, exp_last});
    was_drain = drain;
    if (exp_valid && tr) begin
      for (int i = 0; i < n; i++) void'(q.pop_front());
      if (exp_last) drain = 1'b0;
    end
    if (exp_ready && v[0]) q.push_back(e[7:0]);
    if (exp_ready && v[1]) q.push_back(e[15:8]);
    if (f && !was_drain) drain = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.valid_i  = 2'b00;
    bus.enc_i    = 16'h0000;
    bus.flush_i  = 1'b0;
    bus.m_tready = 1'b0;
    #1;
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_tvalid", {31'd0, bus.m_tvalid}, 32'd0);
    check("rst_tkeep", {28'd0, bus.m_tkeep}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    drain = 1'b0;
  endtask

  initial begin
    bus.valid_i  = 2'b00;
    bus.enc_i    = 16'h0000;
    bus.flush_i  = 1'b0;
    bus.m_tready = 1'b0;
    #1;
    check("reset_tdata", bus.m_tdata, 32'h0);
    check("reset_tlast", {31'd0, bus.m_tlast}, 32'd0);
    do_reset();

    // Four 2-byte beats -> two full words, first valid one cycle after beat 2.
    step(2'b11, 16'h0201, 1'b0, 1'b1);
    step(2'b11, 16'h0403, 1'b0, 1'b1);
    check("t1_not_yet", {31'd0, bus.m_tvalid}, 32'd0);
    step(2'b11, 16'h0605, 1'b0, 1'b1);
    check("t1_word0", bus.m_tdata, 32'h04030201);
    step(2'b11, 16'h0807, 1'b0, 1'b1);
    step(2'b00, 16'h0000, 1'b0, 1'b1);
    check("t1_word1", bus.m_tdata, 32'h08070605);
    check("t1_keep", {28'd0, bus.m_tkeep}, 32'hF);

    // Mixed beat widths.
    do_reset();
    step(2'b01, 16'h00AA, 1'b0, 1'b1);
    step(2'b10, 16'hBB00, 1'b0, 1'b1);
    step(2'b11, 16'hDDCC, 1'b0, 1'b1);
    step(2'b00, 16'h0000, 1'b0, 1'b1);
    check("mixed_word", bus.m_tdata, 32'hDDCCBBAA);

    // Backpressure: buffer fills to 8 bytes, then ready drops.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(2'b11, {8'(2*k+2), 8'(2*k+1)}, 1'b0, 1'b0);
    end
    check("bp_ready_low", {31'd0, bus.ready_o}, 32'd0);
    check("bp_held_word", bus.m_tdata, 32'h04030201);
    for (int k = 0; k < 4; k++) step(2'b00, 16'h0000, 1'b0, 1'b1);

    // Flush after six bytes.
    do_reset();
    step(2'b11, 16'h1211, 1'b0, 1'b1);
    step(2'b11, 16'h1413, 1'b0, 1'b1);
    step(2'b11, 16'h1615, 1'b0, 1'b1);
    check("fl6_word0", bus.m_tdata, 32'h14131211);
    step(2'b00, 16'h0000, 1'b1, 1'b1);
    step(2'b00, 16'h0000, 1'b0, 1'b1);
    check("fl6_tail_data", bus.m_tdata, 32'h00001615);
    check("fl6_tail_keep", {28'd0, bus.m_tkeep}, 32'h3);
    check("fl6_tail_last", {31'd0, bus.m_tlast}, 32'd1);
    check("fl6_ready_drain", {31'd0, bus.ready_o}, 32'd0);
    step(2'b00, 16'h0000, 1'b0, 1'b1);
    check("fl6_ready_after", {31'd0, bus.ready_o}, 32'd1);

    // Flush with an empty buffer -> null TLAST beat.
    step(2'b00, 16'h0000, 1'b1, 1'b1);
    step(2'b00, 16'h0000, 1'b0, 1'b1);
    check("null_keep", {28'd0, bus.m_tkeep}, 32'h0);
    check("null_last", {31'd0, bus.m_tlast}, 32'd1);
    step(2'b00, 16'h0000, 1'b0, 1'b1);

    // Flush coinciding with a 2-byte beat while holding 2 bytes.
    step(2'b11, 16'h2221, 1'b0, 1'b1);
    step(2'b11, 16'h2423, 1'b1, 1'b1);
    step(2'b00, 16'h0000, 1'b0, 1'b1);
    check("flbeat_keep", {28'd0, bus.m_tkeep}, 32'hF);
    check("flbeat_last", {31'd0, bus.m_tlast}, 32'd1);
    check("flbeat_data", bus.m_tdata, 32'h24232221);
    step(2'b00, 16'h0000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a 5-byte drain.
    step(2'b11, 16'h3231, 1'b0, 1'b0);
    step(2'b11, 16'h3433, 1'b0, 1'b0);
    step(2'b01, 16'h0035, 1'b0, 1'b0);
    step(2'b00, 16'h0000, 1'b1, 1'b0);
    step(2'b00, 16'h0000, 1'b0, 1'b0);
    check("ar_in_drain", {31'd0, bus.ready_o}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("ar_tvalid", {31'd0, bus.m_tvalid}, 32'd0);
    check("ar_ready", {31'd0, bus.ready_o}, 32'd1);
    check("ar_tdata", bus.m_tdata, 32'h0);
    check("ar_tlast", {31'd0, bus.m_tlast}, 32'd0);
    #1 rst = 1'b0;
    q.delete();
    drain = 1'b0;
    step(2'b11, 16'hBBAA, 1'b0, 1'b1);
    step(2'b11, 16'hDDCC, 1'b0, 1'b1);
    step(2'b00, 16'h0000, 1'b0, 1'b1);
    check("ar_fresh_word", bus.m_tdata, 32'hDDCCBBAA);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step(2'($urandom_range(0, 3)), 16'($urandom),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7));
    end

`ifdef RANS_PACK_BYTE_CNT_EN
    begin
      bit          seen;
      logic [31:0] total;
      seen  = 1'b0;
      total = 32'd0;
      do_reset();
      step(2'b11, 16'h1211, 1'b0, 1'b1);
      step(2'b11, 16'h1413, 1'b0, 1'b1);
      step(2'b11, 16'h1615, 1'b0, 1'b1);
      step(2'b00, 16'h0000, 1'b1, 1'b1);
      for (int c = 0; c < 12; c++) begin
        step(2'b00, 16'h0000, 1'b0, 1'b1);
        if (stream_done && !seen) begin
          seen  = 1'b1;
          total = byte_cnt;
        end
      end
      check("cnt_done_seen", {31'd0, seen}, 32'd1);
      check("cnt_total", total, 32'd6);
      check("cnt_cleared", byte_cnt, 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
